// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Pong score engine: goal edge detect, 0..WIN_SCORE scores, pause/serve/game-over sequencing; SCORE_KEEPER_SERVE_ALT_EN alternates serve_dir on every serve
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 25000000,
  parameter int CNT_W        = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       new_game,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       serve,
  output logic       serve_dir,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] pause_cnt;

  // Previous-level registers and registered edge pulses for the goal inputs
  logic goal_left_q;
  logic goal_right_q;
  logic left_edge_q;
  logic right_edge_q;

  // A point is awarded only when exactly one goal edge is present
  logic       left_scores;
  logic       right_scores;
  logic [3:0] score_left_inc;
  logic [3:0] score_right_inc;

  assign left_scores     = right_edge_q & ~left_edge_q;
  assign right_scores    = left_edge_q & ~right_edge_q;
  assign score_left_inc  = score_left + 4'd1;
  assign score_right_inc = score_right + 4'd1;

  // Goal rising-edge detection; the pulse is registered so the score lands two clocks after the rise
  always_ff @(posedge clk) begin
    if (reset) begin
      goal_left_q  <= 1'b0;
      goal_right_q <= 1'b0;
      left_edge_q  <= 1'b0;
      right_edge_q <= 1'b0;
    end else begin
      goal_left_q  <= goal_left;
      goal_right_q <= goal_right;
      if (new_game) begin
        // A restart throws away any goal edge still waiting to be scored
        left_edge_q  <= 1'b0;
        right_edge_q <= 1'b0;
      end else begin
        left_edge_q  <= goal_left & ~goal_left_q;
        right_edge_q <= goal_right & ~goal_right_q;
      end
    end
  end

  // Game sequencer: scores, pause countdown, serve pulse and game-over, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pause_cnt   <= CNT_ZERO;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      serve       <= 1'b0;
      serve_dir   <= 1'b0;
      playing     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      serve <= 1'b0;
      if (new_game) begin
        // Start or restart from any state; first serve of a game goes left
        state       <= ST_PAUSE;
        pause_cnt   <= PAUSE_LOAD;
        score_left  <= 4'd0;
        score_right <= 4'd0;
        serve_dir   <= 1'b0;
        playing     <= 1'b0;
        game_over   <= 1'b0;
        winner      <= WIN_NONE;
      end else begin
        case (state)
          ST_IDLE: begin
            playing   <= 1'b0;
            game_over <= 1'b0;
          end

          ST_PAUSE: begin
            if (pause_cnt <= CNT_ONE) begin
              pause_cnt <= CNT_ZERO;
              serve     <= 1'b1;
              playing   <= 1'b1;
              state     <= ST_PLAY;
            end else begin
              pause_cnt <= pause_cnt - CNT_ONE;
            end
          end

          ST_PLAY: begin
            if (left_scores) begin
              score_left <= score_left_inc;
`ifdef SCORE_KEEPER_SERVE_ALT_EN
              serve_dir  <= ~serve_dir;
`else
              // Right player conceded, so the next serve goes toward the right
              serve_dir  <= 1'b1;
`endif
              playing    <= 1'b0;
              if (score_left_inc == WIN_VAL) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
                winner    <= WIN_LEFT;
              end else begin
                state     <= ST_PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end else if (right_scores) begin
              score_right <= score_right_inc;
`ifdef SCORE_KEEPER_SERVE_ALT_EN
              serve_dir   <= ~serve_dir;
`else
              // Left player conceded, so the next serve goes toward the left
              serve_dir   <= 1'b0;
`endif
              playing     <= 1'b0;
              if (score_right_inc == WIN_VAL) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
                winner    <= WIN_RIGHT;
              end else begin
                state     <= ST_PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end
          end

          ST_OVER: begin
            // Scores and winner are frozen until new_game
            game_over <= 1'b1;
            playing   <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - lockstep reference-model bench for score_keeper
module tb_score_keeper;

  localparam int WIN   = 3;
  localparam int PAUSE = 4;
  localparam int CW    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       serve;
  logic       serve_dir;
  logic       playing;
  logic       game_over;
  logic [1:0] winner;

  score_keeper #(
    .WIN_SCORE   (WIN),
    .PAUSE_CYCLES(PAUSE),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .goal_left  (goal_left),
    .goal_right (goal_right),
    .new_game   (new_game),
    .score_left (score_left),
    .score_right(score_right),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .playing    (playing),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: game described as scores, a remaining-pause count and flags
  int m_sl, m_sr, m_wait, m_win;
  bit m_serve, m_dir, m_play, m_over;
  bit m_gl_prev, m_gr_prev, m_pend_l, m_pend_r;

  task automatic model_clock(input bit rst, input bit ng, input bit gl, input bit gr);
    bit new_l, new_r, left_pt, right_pt;
    if (rst) begin
      m_sl = 0; m_sr = 0; m_wait = 0; m_win = 0;
      m_serve = 0; m_dir = 0; m_play = 0; m_over = 0;
      m_gl_prev = 0; m_gr_prev = 0; m_pend_l = 0; m_pend_r = 0;
      return;
    end
    new_l = gl && !m_gl_prev;
    new_r = gr && !m_gr_prev;
    m_gl_prev = gl;
    m_gr_prev = gr;
    m_serve = 0;
    if (ng) begin
      m_sl = 0; m_sr = 0; m_win = 0; m_over = 0; m_play = 0;
      m_wait = PAUSE; m_dir = 0;
      new_l = 0; new_r = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_serve = 1;
        m_play  = 1;
      end
    end else if (m_play) begin
      left_pt  = m_pend_r && !m_pend_l;
      right_pt = m_pend_l && !m_pend_r;
      if (left_pt || right_pt) begin
        if (left_pt) m_sl++; else m_sr++;
`ifdef SCORE_KEEPER_SERVE_ALT_EN
        m_dir = !m_dir;
`else
        m_dir = left_pt;
`endif
        m_play = 0;
        if (m_sl == WIN || m_sr == WIN) begin
          m_over = 1;
          m_win  = left_pt ? 1 : 2;
        end else begin
          m_wait = PAUSE;
        end
      end
    end
    m_pend_l = new_l;
    m_pend_r = new_r;
  endtask

  task automatic step(input bit rst, input bit ng, input bit gl, input bit gr);
    reset = rst; new_game = ng; goal_left = gl; goal_right = gr;
    @(posedge clk);
    model_clock(rst, ng, gl, gr);
    #1;
    check("cycle", {18'd0, score_left, score_right, serve, serve_dir, playing, game_over, winner},
          {18'd0, 4'(m_sl), 4'(m_sr), m_serve, m_dir, m_play, m_over, 2'(m_win)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Bounded wait for the model to enter play, then confirm the DUT agrees
  task automatic wait_play(input string tag);
    for (int i = 0; i < 20 && !m_play; i++) step(0, 0, 0, 0);
    check(tag, {31'd0, playing}, 32'd1);
  endtask

  int serves;

  initial begin
    reset = 1; new_game = 0; goal_left = 0; goal_right = 0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_scores", {24'd0, score_left, score_right}, 32'd0);
    check("rst_flags", {28'd0, serve, serve_dir, playing, game_over}, 32'd0);
    check("rst_winner", {30'd0, winner}, 32'd0);
    idle(3);
    check("idle_no_play", {31'd0, playing}, 32'd0);

    // new_game, serve after PAUSE cycles
    step(0, 1, 0, 0);
    serves = 0;
    for (int i = 0; i < PAUSE - 1; i++) begin
      step(0, 0, 0, 0);
      serves += serve;
    end
    check("serve_early", serves, 0);
    step(0, 0, 0, 0);
    check("serve_after_pause", {31'd0, serve}, 32'd1);
    check("play_after_serve", {31'd0, playing}, 32'd1);
    step(0, 0, 0, 0);
    check("serve_one_cycle", {31'd0, serve}, 32'd0);

    // Hold goal_right for 10 cycles: one point for left, 2 clk after the rise
    step(0, 0, 0, 1);
    check("score_not_yet", {28'd0, score_left}, 32'd0);
    step(0, 0, 0, 1);
    check("score_2clk", {28'd0, score_left}, 32'd1);
    check("pause_after_point", {31'd0, playing}, 32'd0);
    check("dir_after_left_pt", {31'd0, serve_dir}, 32'd1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("held_once", {28'd0, score_left}, 32'd1);
    check("play_after_reserve", {31'd0, playing}, 32'd1);

    // Both goals rise together: nothing happens
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    serves = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      serves += serve;
    end
    check("both_scores", {24'd0, score_left, score_right}, 32'h10);
    check("both_no_serve", serves, 0);
    check("both_still_play", {31'd0, playing}, 32'd1);

    // Two more left points reach WIN
    for (int p = 0; p < 2; p++) begin
      step(0, 0, 0, 1);
      idle(2);
      if (p == 0) wait_play("play_before_win");
    end
    check("win_score", {28'd0, score_left}, 32'd3);
    check("win_over", {31'd0, game_over}, 32'd1);
    check("win_left", {30'd0, winner}, 32'd1);
    step(0, 0, 1, 0);
    idle(3);
    check("over_frozen", {24'd0, score_left, score_right}, 32'h30);

    // new_game from OVER
    step(0, 1, 0, 0);
    check("ng_clear", {22'd0, score_left, score_right, winner}, 32'd0);
    check("ng_not_over", {31'd0, game_over}, 32'd0);
    wait_play("play_after_ng");

    // Reach 2-1, then restart mid-play
    step(0, 0, 0, 1); idle(2); wait_play("p1");
    step(0, 0, 1, 0); idle(2); wait_play("p2");
    step(0, 0, 0, 1); idle(2); wait_play("p3");
    check("score_2_1", {24'd0, score_left, score_right}, 32'h21);
    step(0, 1, 0, 0);
    check("midplay_clear", {24'd0, score_left, score_right}, 32'd0);
    check("midplay_pause", {31'd0, playing}, 32'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_in_pause", {18'd0, score_left, score_right, serve, serve_dir, playing, game_over, winner}, 32'd0);
    serves = 0;
    for (int i = 0; i < 2 * PAUSE; i++) begin
      step(0, 0, 0, 0);
      serves += serve;
    end
    check("no_serve_after_rst", serves, 0);

    // Randomised lockstep run
    begin
      bit gl = 0, gr = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) gl = !gl;
        if ($urandom_range(0, 7) == 0) gr = !gr;
        step($urandom_range(0, 599) == 0, $urandom_range(0, 149) == 0, gl, gr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
